flit_splitter: RTL and testbench

- Parametrised successor of the fixed 64-bit/4-flit NoC splitter.
- Buffers whole request packets from the core-side converter in a FIFO and serialises each into FLITS = PAYLOAD_W/FLIT_DATA_W flits for the mesh router's local port.
- Computes the {x,y} destination encoding arithmetically from mesh dimensions.
- Uses a true valid/ready output handshake: a flit is held stable until the router accepts it.

---
 rtl/flit_splitter.sv | 127 ++++++++++++
 tb/tb_flit_splitter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/flit_splitter.sv
// Packet FIFO + serialiser: buffers whole request packets and emits them as
// MSB-chunk-first flits with a valid/ready output. SPLITTER_PARITY_EN appends an even-parity LSB.
module flit_splitter #(
  parameter int NODE_ID         = 0,
  parameter int MESH_COLS       = 3,
  parameter int MESH_ROWS       = 3,
  parameter int PAYLOAD_W       = 64,
  parameter int FLIT_DATA_W     = 16,
  parameter int QUEUE_DEPTH     = 8,
  parameter int PACKET_ID_WIDTH = 5,
  localparam int NODE_COUNT = MESH_COLS * MESH_ROWS,
  localparam int DEST_W     = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1,
  localparam int FLITS      = PAYLOAD_W / FLIT_DATA_W,
  localparam int MAX_DIM    = (MESH_COLS > MESH_ROWS) ? MESH_COLS : MESH_ROWS,
  localparam int CW         = (MAX_DIM > 2) ? $clog2(MAX_DIM) : 1,
  localparam int IDX_W      = (FLITS > 2) ? $clog2(FLITS) : 1,
  localparam int FLIT_W     = 1 + 2*CW + FLIT_DATA_W + 3 + PACKET_ID_WIDTH + 2*CW + IDX_W,
  localparam int OCC_W      = $clog2(QUEUE_DEPTH) + 1,
`ifdef SPLITTER_PARITY_EN
  localparam int OUT_W      = FLIT_W + 1
`else
  localparam int OUT_W      = FLIT_W
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic [PAYLOAD_W-1:0]       in_data,
  input  logic [2:0]                 in_instr,
  input  logic [DEST_W-1:0]          in_dest,
  input  logic [PACKET_ID_WIDTH-1:0] in_id,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OUT_W-1:0]           out_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OCC_W-1:0]           occupancy
);
  localparam int AW = OCC_W - 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0]       data;
    logic [2:0]                 instr;
    logic [PACKET_ID_WIDTH-1:0] id;
    logic [2*CW-1:0]            dest;
  } pkt_t;

  // Linear node index -> {x,y}; out-of-mesh indices map to all-ones.
  function automatic logic [2*CW-1:0] xy_enc(input int d);
    int x, y;
    if (d >= NODE_COUNT) return '1;
    x = d % MESH_COLS;
    y = d / MESH_COLS;
    return {x[CW-1:0], y[CW-1:0]};
  endfunction

  localparam logic [2*CW-1:0] SRC_XY = xy_enc(NODE_ID);

  pkt_t                               mem [QUEUE_DEPTH];
  pkt_t                               wr_pkt, hd_pkt;
  logic [AW-1:0]                      head, tail;
  logic [AW:0]                        count;
  logic [IDX_W-1:0]                   idx;
  logic                               push, pop, load, drain, last;
  logic [FLITS-1:0][FLIT_DATA_W-1:0]  chunks;
  logic [FLIT_W-1:0]                  nxt_flit;
  logic [OUT_W-1:0]                   nxt_out;

  assign in_ready  = (count != (AW+1)'(QUEUE_DEPTH));
  assign occupancy = count;
  assign push      = ce & in_valid & in_ready;

  assign wr_pkt.data  = in_data;
  assign wr_pkt.instr = in_instr;
  assign wr_pkt.id    = in_id;
  assign wr_pkt.dest  = xy_enc(int'(in_dest));

  always_ff @(posedge clk)
    if (push) mem[tail] <= wr_pkt;

  assign hd_pkt = mem[head];

  for (genvar k = 0; k < FLITS; k++) begin : g_chunk
    assign chunks[k] = hd_pkt.data[PAYLOAD_W-1-k*FLIT_DATA_W -: FLIT_DATA_W];
  end

  // Output register refills whenever it is empty or its flit is being taken.
  assign load  = ce & (count != '0) & (~out_valid | out_ready);
  assign last  = (idx == IDX_W'(FLITS - 1));
  assign pop   = load & last;
  assign drain = ce & out_valid & out_ready & (count == '0);

  assign nxt_flit = {1'b1, hd_pkt.dest, chunks[idx], hd_pkt.instr, hd_pkt.id, SRC_XY, idx};
`ifdef SPLITTER_PARITY_EN
  assign nxt_out = {nxt_flit, ^nxt_flit};
`else
  assign nxt_out = nxt_flit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      idx   <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
      if (load) idx <= last ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_flit  <= nxt_out;
    end else if (drain) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end
  end
endmodule

// File: tb/tb_flit_splitter.sv
// Directed bench for flit_splitter (NODE_ID=4, 3x3 mesh, 64b payload, 4 flits).
module tb_flit_splitter;
`ifdef SPLITTER_PARITY_EN
  localparam int OUT_W = 36;
`else
  localparam int OUT_W = 35;
`endif

  logic             clk, rst_n, ce;
  logic [63:0]      in_data;
  logic [2:0]       in_instr;
  logic [3:0]       in_dest;
  logic [4:0]       in_id;
  logic             in_valid, in_ready;
  logic [OUT_W-1:0] out_flit;
  logic             out_valid, out_ready;
  logic [3:0]       occupancy;

  int nvec = 0;
  int nerr = 0;

  // hand-computed {x,y} for dest 0..8 on a 3-column mesh
  logic [3:0] enc_tab [9] = '{4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0101,
                              4'b1001, 4'b0010, 4'b0110, 4'b1010};

  flit_splitter #(.NODE_ID(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_data(in_data), .in_instr(in_instr), .in_dest(in_dest), .in_id(in_id),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pdata(input int q);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) d[63-16*k -: 16] = 16'(32'hA000 + q*16 + k);
    return d;
  endfunction

  function automatic logic [OUT_W-1:0] ef(input logic [3:0] d, input logic [15:0] c,
                                         input logic [2:0] ins, input logic [4:0] id,
                                         input logic [1:0] k);
    logic [34:0] f;
    f = {1'b1, d, c, ins, id, 4'b0101, k};
`ifdef SPLITTER_PARITY_EN
    return {f, ^f};
`else
    return f;
`endif
  endfunction

  task automatic exp_flit(input string tag, input logic [3:0] d, input logic [63:0] data,
                          input logic [2:0] ins, input logic [4:0] id, input int k);
    logic [63:0] dd;
    dd = data;
    chk($sformatf("%s_v%0d", tag, k), 64'(out_valid), 64'd1);
    chk($sformatf("%s_f%0d", tag, k), 64'(out_flit), 64'(ef(d, dd[63-16*k -: 16], ins, id, 2'(k))));
  endtask

  task automatic set_pkt(input logic [63:0] d, input logic [3:0] dst,
                         input logic [2:0] ins, input logic [4:0] id);
    in_data = d; in_dest = dst; in_instr = ins; in_id = id;
  endtask

  task automatic set_q(input int q);
    set_pkt(pdata(q), 4'(q % 9), 3'(q), 5'(q));
  endtask

  task automatic exp_q(input string tag, input int q, input int k);
    exp_flit(tag, enc_tab[q % 9], pdata(q), 3'(q), 5'(q), k);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v"}, 64'(out_valid), 64'd0);
    chk({tag, "_f"}, 64'(out_flit), 64'd0);
  endtask

  initial begin
    int drain_q [8] = '{1, 2, 3, 4, 5, 6, 7, 10};
    rst_n = 0; ce = 1; in_valid = 0; out_ready = 1;
    set_pkt(64'd0, 4'd0, 3'd0, 5'd0);
    #12;
    chk_idle("rst");
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1;
    step;

    // basic packet
    set_pkt(64'h1111_2222_3333_4444, 4'd5, 3'b010, 5'd7);
    in_valid = 1; step; in_valid = 0;
    chk("t1_lat", 64'(out_valid), 64'd0);
    chk("t1_occ", 64'(occupancy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step; exp_flit("t1", 4'b1001, 64'h1111_2222_3333_4444, 3'b010, 5'd7, k);
    end
    step; chk_idle("t1_idle");

    // backpressure at flit 1
    set_pkt(64'h1111_2222_3333_4444, 4'd5, 3'b001, 5'd8);
    in_valid = 1; step; in_valid = 0;
    step; exp_flit("t2", 4'b1001, 64'h1111_2222_3333_4444, 3'b001, 5'd8, 0);
    step; exp_flit("t2", 4'b1001, 64'h1111_2222_3333_4444, 3'b001, 5'd8, 1);
    out_ready = 0;
    repeat (5) begin
      step; exp_flit("t2_hold", 4'b1001, 64'h1111_2222_3333_4444, 3'b001, 5'd8, 1);
    end
    out_ready = 1;
    step; exp_flit("t2", 4'b1001, 64'h1111_2222_3333_4444, 3'b001, 5'd8, 2);
    step; exp_flit("t2", 4'b1001, 64'h1111_2222_3333_4444, 3'b001, 5'd8, 3);
    step; chk_idle("t2_idle");

    // fill the FIFO
    out_ready = 0;
    for (int q = 0; q < 8; q++) begin
      chk($sformatf("t3_rdy%0d", q), 64'(in_ready), 64'd1);
      set_q(q); in_valid = 1; step;
    end
    in_valid = 0;
    chk("t3_occ_full", 64'(occupancy), 64'd8);
    chk("t3_rdy_full", 64'(in_ready), 64'd0);
    exp_q("t3_p0", 0, 0);
    set_q(9); in_valid = 1; step; step; in_valid = 0;
    chk("t3_ninth", 64'(occupancy), 64'd8);
    out_ready = 1;
    for (int k = 1; k < 4; k++) begin
      step; exp_q("t3_p0", 0, k);
    end
    chk("t3_occ_pop", 64'(occupancy), 64'd7);
    chk("t3_rdy_pop", 64'(in_ready), 64'd1);
    out_ready = 0;
    set_q(10); in_valid = 1; step; in_valid = 0;
    chk("t3_occ_refill", 64'(occupancy), 64'd8);
    chk("t3_rdy_refill", 64'(in_ready), 64'd0);
    exp_q("t3_p0_hold", 0, 3);
    out_ready = 1;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++) begin
        step; exp_q($sformatf("t3_p%0d", drain_q[i]), drain_q[i], k);
      end
    step; chk_idle("t3_idle");
    chk("t3_occ_end", 64'(occupancy), 64'd0);

    // back-to-back stream, push coincides with pop at each packet boundary
    for (int e = 0; e < 82; e++) begin
      if (e % 4 == 0 && e < 80) begin set_q(e / 4); in_valid = 1; end
      else in_valid = 0;
      step;
      if (e >= 1 && e <= 80) exp_q($sformatf("t4_p%0d", (e-1)/4), (e-1)/4, (e-1)%4);
      if (e >= 1 && e <= 79) chk($sformatf("t4_occ%0d", e), 64'(occupancy), 64'd1);
      if (e == 81) chk_idle("t4_idle");
    end

    // invalid destination and clock enable
    set_pkt(pdata(50), 4'd9, 3'b111, 5'd3);
    in_valid = 1; step; in_valid = 0;
    step; exp_flit("t5", 4'b1111, pdata(50), 3'b111, 5'd3, 0);
    step; exp_flit("t5", 4'b1111, pdata(50), 3'b111, 5'd3, 1);
    ce = 0; set_q(1); in_valid = 1;
    repeat (3) begin
      step;
      exp_flit("t5_ce", 4'b1111, pdata(50), 3'b111, 5'd3, 1);
      chk("t5_ce_occ", 64'(occupancy), 64'd1);
      chk("t5_ce_rdy", 64'(in_ready), 64'd1);
    end
    ce = 1; in_valid = 0;
    step; exp_flit("t5", 4'b1111, pdata(50), 3'b111, 5'd3, 2);
    step; exp_flit("t5", 4'b1111, pdata(50), 3'b111, 5'd3, 3);
    step; chk_idle("t5_idle");

    // reset mid-packet
    set_q(2); in_valid = 1; step;
    set_q(3); step; in_valid = 0;
    exp_q("t6", 2, 0);
    step; exp_q("t6", 2, 1);
    #2 rst_n = 0;
    #1;
    chk_idle("t6_rst");
    chk("t6_rst_occ", 64'(occupancy), 64'd0);
    chk("t6_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step; chk($sformatf("t6_post%0d", i), 64'(out_valid), 64'd0);
    end
    chk("t6_post_occ", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
